// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign fix-up.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        AnyStall,
   input  logic        Valid_EX,
   input  logic [2:0]  Op_EX,
   input  logic [31:0] SrcA_EX,
   input  logic [31:0] SrcB_EX,
   output logic [31:0] Result_MD,
   output logic        Stall_EX,
   output logic        Busy_MD,
   output logic        Done_MD,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] b_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        is_div_q;
   logic        neg_q;
   logic        rneg_q;
   logic        dz_q;
   logic        done_q;

   logic        idle;
   logic        take;
   logic        start;
   logic        mt;
   logic        sa;
   logic        sb;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] msum;
   logic [63:0] mul_d;
   logic [32:0] dcand;
   logic [32:0] ddiff;
   logic [63:0] div_d;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign idle  = (state_q == S_IDLE);
   assign take  = Valid_EX & ~AnyStall & idle;
   assign start = take & ~Op_EX[2];
   assign mt    = take & (Op_EX[2:1] == 2'b10);

   // Even opcodes (MULT, DIV) are the signed variants.
   assign sa    = SrcA_EX[31] & ~Op_EX[0];
   assign sb    = SrcB_EX[31] & ~Op_EX[0];
   assign abs_a = sa ? -SrcA_EX : SrcA_EX;
   assign abs_b = sb ? -SrcB_EX : SrcB_EX;

   assign msum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
   assign mul_d = {msum, acc_q[31:1]};

   // Remainder lives in acc_q[63:32], dividend/quotient shifts through [31:0].
   assign dcand = acc_q[63:31];
   assign ddiff = dcand - {1'b0, b_q};
   assign div_d = ddiff[32] ? {dcand[31:0], acc_q[30:0], 1'b0}
                            : {ddiff[31:0], acc_q[30:0], 1'b1};

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quo_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
   assign rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         acc_q    <= 64'd0;
         b_q      <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  acc_q    <= {32'd0, abs_a};
                  b_q      <= abs_b;
                  is_div_q <= Op_EX[1];
                  neg_q    <= sa ^ sb;
                  rneg_q   <= sa;
                  dz_q     <= (SrcB_EX == 32'd0);
                  cnt_q    <= 5'd0;
                  state_q  <= Op_EX[1] ? S_DIV : S_MUL;
               end else if (mt) begin
                  if (Op_EX[0]) lo_q <= SrcA_EX;
                  else          hi_q <= SrcA_EX;
               end
            end
            S_MUL: begin
               acc_q <= mul_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= S_FIX;
            end
            S_DIV: begin
               acc_q <= div_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= S_FIX;
            end
            S_FIX: begin
               if (!is_div_q) begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end else if (dz_q) begin
                  // Remainder holds |dividend|; rem_fix restores the raw value.
                  hi_q <= rem_fix;
                  lo_q <= 32'hFFFF_FFFF;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Busy_MD   = ~idle;
   assign Stall_EX  = Valid_EX & Busy_MD;
   assign Done_MD   = done_q;
   assign Hi        = hi_q;
   assign Lo        = lo_q;
   assign Result_MD = (Op_EX == 3'd6) ? hi_q :
                      (Op_EX == 3'd7) ? lo_q : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic HI/LO model.
// Checks timing of Busy/Done/Stall and results of mul/div/mt operations.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        AnyStall;
   logic        Valid_EX;
   logic [2:0]  Op_EX;
   logic [31:0] SrcA_EX;
   logic [31:0] SrcB_EX;
   logic [31:0] Result_MD;
   logic        Stall_EX;
   logic        Busy_MD;
   logic        Done_MD;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk       (clk),
      .reset     (reset),
      .AnyStall  (AnyStall),
      .Valid_EX  (Valid_EX),
      .Op_EX     (Op_EX),
      .SrcA_EX   (SrcA_EX),
      .SrcB_EX   (SrcB_EX),
      .Result_MD (Result_MD),
      .Stall_EX  (Stall_EX),
      .Busy_MD   (Busy_MD),
      .Done_MD   (Done_MD),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = 64'd0;
      case (op)
         3'd0: res = sa * sb;
         3'd1: res = {32'd0, a} * {32'd0, b};
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else if (op == 3'd2) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end else begin
               res = {a % b, a / b};
            end
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         4: v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Call just after a negedge. mode 0: quiet, 1: junk ops while busy,
   // 2: MFLO held from about T+5 on.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int mode);
      logic [63:0] r;
      r = model(op, a, b);
      Valid_EX = 1'b1;
      AnyStall = 1'b0;
      Op_EX    = op;
      SrcA_EX  = a;
      SrcB_EX  = b;
      @(posedge clk);
      #1 Valid_EX = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         check("busy", {63'd0, Busy_MD}, 64'd1);
         check("done_early", {63'd0, Done_MD}, 64'd0);
         check("stall", {63'd0, Stall_EX}, {63'd0, Valid_EX});
         if (mode == 1 && k < 33) begin
            Valid_EX = 1'($urandom_range(0, 1));
            AnyStall = 1'($urandom_range(0, 1));
            Op_EX    = 3'($urandom_range(0, 7));
            SrcA_EX  = $urandom;
            SrcB_EX  = $urandom;
         end else if (mode == 2 && k >= 4) begin
            Valid_EX = 1'b1;
            Op_EX    = 3'd7;
         end else begin
            Valid_EX = 1'b0;
            AnyStall = 1'b0;
         end
      end
      m_hi = r[63:32];
      m_lo = r[31:0];
      @(negedge clk);
      check("busy_end", {63'd0, Busy_MD}, 64'd0);
      check("done", {63'd0, Done_MD}, 64'd1);
      check("stall_end", {63'd0, Stall_EX}, 64'd0);
      check("hi", {32'd0, Hi}, {32'd0, m_hi});
      check("lo", {32'd0, Lo}, {32'd0, m_lo});
      if (mode == 2) check("mflo_held", {32'd0, Result_MD}, {32'd0, m_lo});
      Valid_EX = 1'b0;
      Op_EX    = 3'd6;
      #1 check("mfhi", {32'd0, Result_MD}, {32'd0, m_hi});
      Op_EX    = 3'd7;
      #1 check("mflo", {32'd0, Result_MD}, {32'd0, m_lo});
      @(negedge clk);
      check("done_pulse", {63'd0, Done_MD}, 64'd0);
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] v);
      Valid_EX = 1'b1;
      AnyStall = 1'b0;
      Op_EX    = op;
      SrcA_EX  = v;
      SrcB_EX  = $urandom;
      @(posedge clk);
      #1 Valid_EX = 1'b0;
      if (op == 3'd4) m_hi = v;
      else            m_lo = v;
      @(negedge clk);
      check("mt_hi", {32'd0, Hi}, {32'd0, m_hi});
      check("mt_lo", {32'd0, Lo}, {32'd0, m_lo});
      check("mt_busy", {63'd0, Busy_MD}, 64'd0);
   endtask

   initial begin
      reset    = 1'b0;
      AnyStall = 1'b0;
      Valid_EX = 1'b1;
      Op_EX    = 3'd0;
      SrcA_EX  = 32'd0;
      SrcB_EX  = 32'd0;
      #12;
      check("rst_hi", {32'd0, Hi}, 64'd0);
      check("rst_lo", {32'd0, Lo}, 64'd0);
      check("rst_busy", {63'd0, Busy_MD}, 64'd0);
      check("rst_done", {63'd0, Done_MD}, 64'd0);
      check("rst_stall", {63'd0, Stall_EX}, 64'd0);
      check("rst_result", {32'd0, Result_MD}, 64'd0);
      @(negedge clk);
      Valid_EX = 1'b0;
      reset    = 1'b1;

      run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1);
      run_op(3'd3, 32'h0000_0007, 32'h0000_0000, 0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 0);

      // AnyStall at the accept edge must block the start.
      Valid_EX = 1'b1;
      AnyStall = 1'b1;
      Op_EX    = 3'd0;
      SrcA_EX  = 32'd5;
      SrcB_EX  = 32'd6;
      @(posedge clk);
      #1 Valid_EX = 1'b0;
      AnyStall = 1'b0;
      @(negedge clk);
      check("anystall_busy", {63'd0, Busy_MD}, 64'd0);
      check("anystall_lo", {32'd0, Lo}, {32'd0, m_lo});

      // Reset in the middle of a MULT aborts it.
      mt(3'd4, 32'h1234_5678);
      Valid_EX = 1'b1;
      Op_EX    = 3'd0;
      SrcA_EX  = 32'd9;
      SrcB_EX  = 32'd9;
      @(posedge clk);
      #1 Valid_EX = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_hi", {32'd0, Hi}, 64'd0);
      check("abort_lo", {32'd0, Lo}, 64'd0);
      check("abort_busy", {63'd0, Busy_MD}, 64'd0);
      check("abort_done", {63'd0, Done_MD}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      run_op(3'd1, 32'h0001_0000, 32'h0003_0000, 0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0)
            mt(3'($urandom_range(4, 5)), $urandom);
         run_op(3'($urandom_range(0, 3)), pick(), pick(),
                int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; reset==0 SHALL clear state immediately, independent of clk.
REQ-004 AnyStall  input  1  global pipeline stall; while 1, no new operation SHALL be accepted.
REQ-005 Valid_EX  input  1  an EX-stage instruction targets this unit this cycle.
REQ-006 Op_EX  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6=MFHI, 7=MFLO.
REQ-007 SrcA_EX  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source).
REQ-008 SrcB_EX  input  32  rt operand (multiplier/divisor).
REQ-009 Result_MD  output  32  MFHI/MFLO read data, combinational from HI/LO.
REQ-010 Stall_EX  output  1  request to hold the EX stage.
REQ-011 Busy_MD  output  1  iterative operation in progress.
REQ-012 Done_MD  output  1  one-cycle pulse after HI/LO commit.
REQ-013 Hi, Lo  output  32 each  architectural HI/LO registers.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX; 5-bit iteration counter.
REQ-015 Accept: Valid_EX & ~AnyStall & IDLE & Op in {0..3} at cycle T SHALL latch operands, go MUL (Op 0,1) or DIV (Op 2,3).
REQ-016 Signed ops SHALL latch absolute values and record result sign(s); unsigned ops SHALL latch raw values.
REQ-017 MUL: radix-2 shift-add, one bit per cycle, 64-bit product, exactly 32 cycles (T+1..T+32).
REQ-018 DIV: restoring division, one quotient bit per cycle, exactly 32 cycles (T+1..T+32).
REQ-019 FIX (T+33): apply sign correction, write HI/LO at the closing edge; return to IDLE.
REQ-020 MULT/MULTU: HI=product[63:32], LO=product[31:0]; MULT product SHALL be negated iff operand signs differ.
REQ-021 DIV/DIVU: LO=quotient, HI=remainder; signed quotient negative iff signs differ; signed remainder SHALL take dividend's sign.
REQ-022 Divide by zero (any div): HI=SrcA_EX as latched (unmodified), LO=0xFFFFFFFF; still 33 busy cycles.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-024 Busy_MD SHALL be 1 in cycles T+1..T+33, else 0.
REQ-025 Done_MD SHALL be 1 only in cycle T+34; new HI/LO visible from T+34.
REQ-026 MTHI/MTLO accepted in IDLE (Valid_EX & ~AnyStall) SHALL write HI/LO at that edge, single cycle, no Busy.
REQ-027 MFHI/MFLO: Result_MD SHALL equal HI (Op 6) or LO (Op 7), else 0x00000000.
REQ-028 Stall_EX = Valid_EX & Busy_MD, any Op; an issuing mul/div at T SHALL NOT itself assert Stall_EX at T.
REQ-029 Ops presented while Busy_MD=1 SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-030 AnyStall SHALL NOT pause an in-flight iteration; counter advances every cycle.
REQ-031 Op FIX SHALL take priority: MTHI/MTLO cannot coincide with FIX because Stall_EX holds them.

Reset
REQ-032 reset==0 SHALL force IDLE, counter=0, HI=LO=0, Busy_MD=0, Done_MD=0, Stall_EX=Valid_EX&0=0, Result_MD=0 if Op not 6/7.
REQ-033 reset asserted mid-operation SHALL abort it; HI/LO SHALL read 0, no Done_MD pulse after release.
REQ-034 First accept SHALL be possible on the first posedge after reset deasserts.

Verification
REQ-035 MULT 0xFFFFFFFE x 0x00000003 -> at T+34 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done_MD pulse one cycle.
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; Busy_MD high exactly 33 cycles.
REQ-037 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 MFLO issued at T+5 with Valid_EX held -> Stall_EX=1 through T+33, Result_MD=new LO at T+34, Stall_EX=0 at T+34.
REQ-040 MTHI 0x12345678 then reset low at T+10 of a MULT -> HI=LO=0, IDLE, no Done_MD; AnyStall=1 at accept cycle -> no start.
